// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: first-word-fall-through read port,
// occupancy/almost-full/full flags decoded from the registered count, sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic              i_Clock,
    input  logic              i_reset,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Data,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [7:0]        o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_COUNT = (ADDR_W + 1)'(AFULL_LEVEL);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;

    logic pop;
    logic push;
    logic overflow_evt;

    always_comb begin
        o_empty       = (count == '0);
        o_full        = (count == FULL_COUNT);
        o_almost_full = (count >= AFULL_COUNT);
        o_rd_valid    = !o_empty;
        o_count       = count;
        o_overflow    = overflow;
        o_rd_data     = mem[rd_ptr];

        pop  = i_rd_ready && o_rd_valid;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push         = i_RX_DV && (!o_full || pop);
        overflow_evt = i_RX_DV && o_full && !pop;
    end

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge i_Clock) begin
        if (push && !i_reset) begin
            mem[wr_ptr] <= i_RX_Data;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            // A fresh drop outranks a coincident clear so no loss goes unreported.
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
